// File: rtl/color_select.sv
// Joystick-driven palette colour source for the vga stage.
// Steps are queued in idx_pend and shown only at the start of vertical sync.
module color_select #(
  parameter int unsigned REPEAT_DELAY  = 12_558_140,
  parameter int unsigned REPEAT_RATE   = 3_139_535,
  parameter bit          VS_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [31:0] joy,
  input  logic        vs,
  output logic [7:0]  color,
  output logic [2:0]  index,
  output logic        changed
);

  localparam logic [23:0] DLY_LD  = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] RATE_LD = 24'(REPEAT_RATE - 1);
  localparam logic        VS_IDLE = VS_ACTIVE_LOW;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  function automatic logic [7:0] pal(input logic [2:0] i);
    case (i)
      3'd0: pal = 8'hFF;
      3'd1: pal = 8'hE0;
      3'd2: pal = 8'h1C;
      3'd3: pal = 8'h03;
      3'd4: pal = 8'hFC;
      3'd5: pal = 8'h1F;
      3'd6: pal = 8'hE3;
      default: pal = 8'h00;
    endcase
  endfunction

  logic [5:0]  joy_q;
  logic        b_q;
  logic        vs_q, vs_qq;
  logic [2:0]  idx_pend;
  logic [23:0] cnt;
  logic        dir_lat;
  state_t      state;

  logic unused_joy;
  assign unused_joy = ^joy[31:6];

  // right xor left, and B masks any direction
  logic       dir_v, dir_r, b_rise, sync_edge;
  logic [2:0] idx_step;
  logic [7:0] new_color;
  assign dir_v     = (joy_q[0] ^ joy_q[1]) & ~joy_q[5];
  assign dir_r     = joy_q[0];
  assign idx_step  = dir_r ? idx_pend + 3'd1 : idx_pend - 3'd1;
  assign b_rise    = joy_q[5] & ~b_q;
  assign sync_edge = (vs_q != VS_IDLE) && (vs_qq == VS_IDLE);
  assign new_color = joy_q[4] ? 8'hE0 : pal(idx_pend);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy_q <= '0;
      b_q   <= 1'b0;
      vs_q  <= VS_IDLE;
      vs_qq <= VS_IDLE;
    end else begin
      joy_q <= joy[5:0];
      b_q   <= joy_q[5];
      vs_q  <= vs;
      vs_qq <= vs_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx_pend <= '0;
      cnt      <= '0;
      dir_lat  <= 1'b0;
    end else if (b_rise) begin
      state    <= IDLE;
      idx_pend <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dir_v) begin
            idx_pend <= idx_step;
            dir_lat  <= dir_r;
            cnt      <= DLY_LD;
            state    <= DELAY;
          end
        end
        default: begin
          if (!dir_v) begin
            state <= IDLE;
          end else if (dir_r != dir_lat) begin
            idx_pend <= idx_step;
            dir_lat  <= dir_r;
            cnt      <= DLY_LD;
            state    <= DELAY;
          end else if (cnt == '0) begin
            idx_pend <= idx_step;
            cnt      <= RATE_LD;
            state    <= REPEAT;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
      endcase
    end
  end

  // apply uses the pre-step idx_pend when a step lands on the sync edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      color   <= 8'hFF;
      index   <= '0;
      changed <= 1'b0;
    end else if (sync_edge) begin
      color   <= new_color;
      index   <= idx_pend;
      changed <= (new_color != color);
    end else begin
      changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_color_select.sv
// Directed bench for color_select with short repeat timing (delay 10, rate 4).
module tb_color_select;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [31:0] joy;
  logic        vs;
  logic [7:0]  color;
  logic [2:0]  index;
  logic        changed;

  int checks = 0;
  int errors = 0;

  color_select #(.REPEAT_DELAY(10), .REPEAT_RATE(4), .VS_ACTIVE_LOW(1'b1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .joy(joy), .vs(vs),
    .color(color), .index(index), .changed(changed)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // vs low for 3 clocks then high for 3; bit k of mask = changed after edge k
  task automatic vs_pulse(output logic [5:0] mask);
    mask = '0;
    vs = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) vs = 1'b1;
      tick();
      mask[k] = changed;
    end
  endtask

  logic [5:0] m;

  initial begin
    reset_n = 1'b0;
    joy     = '0;
    vs      = 1'b1;
    tick(2);
    check("reset_color", color, 8'hFF);
    check("reset_index", index, 3'd0);
    check("reset_changed", changed, 1'b0);
    reset_n = 1'b1;
    tick(2);

    vs_pulse(m);
    check("idle_color", color, 8'hFF);
    check("idle_index", index, 3'd0);
    check("idle_nochg", m, 6'b0);

    // right tap: single step
    joy = 32'h1;
    tick(3);
    joy = '0;
    tick(2);
    check("tap_pend", dut.idx_pend, 3'd1);
    vs_pulse(m);
    check("tap_color", color, 8'hE0);
    check("tap_index", index, 3'd1);
    check("tap_chg_timing", m, 6'b000010);

    // right held: steps at N+1, N+11, +15, +19, +23, +27, +31
    joy = 32'h1;
    tick(1);
    check("hold_n0", dut.idx_pend, 3'd1);
    tick(1);
    check("hold_press", dut.idx_pend, 3'd2);
    tick(9);
    check("hold_pre_rep", dut.idx_pend, 3'd2);
    tick(1);
    check("hold_rep1", dut.idx_pend, 3'd3);
    tick(3);
    check("hold_pre_rep2", dut.idx_pend, 3'd3);
    tick(1);
    check("hold_rep2", dut.idx_pend, 3'd4);
    tick(12);
    check("hold_rep5", dut.idx_pend, 3'd7);
    tick(3);
    check("hold_pre_wrap", dut.idx_pend, 3'd7);
    tick(1);
    check("hold_wrap", dut.idx_pend, 3'd0);
    joy = '0;
    tick(3);
    check("hold_release", dut.idx_pend, 3'd0);

    // left from 0 wraps to 7; both directions do nothing
    joy = 32'h2;
    tick(2);
    joy = '0;
    tick(3);
    check("left_wrap", dut.idx_pend, 3'd7);
    joy = 32'h3;
    tick(15);
    check("both_none", dut.idx_pend, 3'd7);
    joy = '0;
    tick(2);

    // A forces red; same colour as before so no pulse
    joy = 32'h10;
    tick(2);
    vs_pulse(m);
    check("a_color", color, 8'hE0);
    check("a_index", index, 3'd7);
    check("a_nochg", m, 6'b0);
    joy = '0;
    tick(2);
    vs_pulse(m);
    check("a_rel_color", color, 8'h00);
    check("a_rel_index", index, 3'd7);
    check("a_rel_chg", m, 6'b000010);

    // two left taps to reach 5
    for (int t = 0; t < 2; t++) begin
      joy = 32'h2;
      tick(3);
      joy = '0;
      tick(3);
    end
    check("at_five", dut.idx_pend, 3'd5);

    // B while right held
    joy = 32'h1;
    tick(2);
    check("b_pre_step", dut.idx_pend, 3'd6);
    joy = 32'h21;
    tick(2);
    check("b_clear", dut.idx_pend, 3'd0);
    tick(12);
    check("b_held", dut.idx_pend, 3'd0);
    joy = 32'h1;
    tick(1);
    check("b_rel_wait", dut.idx_pend, 3'd0);
    tick(1);
    check("b_rel_step", dut.idx_pend, 3'd1);
    tick(3);

    // async reset mid-DELAY
    reset_n = 1'b0;
    #1;
    check("arst_color", color, 8'hFF);
    check("arst_index", index, 3'd0);
    check("arst_pend", dut.idx_pend, 3'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("rel_no_step", dut.idx_pend, 3'd0);
    tick(1);
    check("rel_press", dut.idx_pend, 3'd1);
    joy = '0;
    tick(3);
    vs_pulse(m);
    check("final_color", color, 8'hE0);
    check("final_chg", m, 6'b000010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
